// File: rtl/life_pkg.sv
// rtl/life_pkg.sv - shared Life cell state encoding and frame capture FSM types
package life_pkg;

    // Cycles per generation, fixed by the cell's load + 7-step evaluate sequence.
    localparam int GEN_PERIOD = 7;

    // Cell sequencing states; identical encoding to the cell so trackers can mirror it.
    typedef enum logic [2:0] {
        LIFE_LOAD = 3'b000,
        LIFE_S1   = 3'b001,
        LIFE_S2   = 3'b010,
        LIFE_S3   = 3'b011,
        LIFE_S4   = 3'b100,
        LIFE_S5   = 3'b101,
        LIFE_S6   = 3'b110,
        LIFE_S7   = 3'b111
    } life_state_t;

    // Output streaming FSM.
    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } cap_fsm_t;

    // Successor of a cell state: LOAD leaves once, then the loop wraps from last_phase to S1.
    function automatic life_state_t life_next_state(input life_state_t cur,
                                                    input logic [2:0]  last_phase);
        logic [2:0] nxt;
        if ((cur == LIFE_LOAD) || (cur == last_phase)) begin
            return LIFE_S1;
        end
        nxt = cur + 3'd1;
        return life_state_t'(nxt);
    endfunction

endpackage

// File: rtl/life_phase_tracker.sv
// rtl/life_phase_tracker.sv - mirrors the cell state sequence and strobes the capture phase
module life_phase_tracker #(
    parameter int GEN_PERIOD = life_pkg::GEN_PERIOD
) (
    input  logic clk,
    input  logic nrst,
    output logic cap_stb_o
);

    import life_pkg::life_state_t;
    import life_pkg::LIFE_LOAD;
    import life_pkg::LIFE_S1;
    import life_pkg::life_next_state;

    localparam logic [2:0] LAST_PHASE = 3'(GEN_PERIOD);

    life_state_t mirror_q;
    life_state_t mirror_d;

    // Advance the mirror exactly as the cells advance their own state.
    always_comb begin
        mirror_d = life_next_state(mirror_q, LAST_PHASE);
    end

    // Mirror register; shares the cells' reset so both leave LOAD on the same edge.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            mirror_q <= LIFE_LOAD;
        end else begin
            mirror_q <= mirror_d;
        end
    end

    // Phase 1 is the first state after the cells have settled a new generation.
    assign cap_stb_o = (mirror_q == LIFE_S1);

endmodule

// File: rtl/life_frame_capture.sv
// rtl/life_frame_capture.sv - snapshots the Life array once per generation and streams it by row
module life_frame_capture #(
    parameter  int WIDTH      = 8,
    parameter  int HEIGHT     = 6,
    parameter  int GEN_PERIOD = life_pkg::GEN_PERIOD,
    localparam int ROW_W      = (HEIGHT > 1) ? $clog2(HEIGHT) : 1
) (
    input  logic                    clk,
    input  logic                    nrst,
    input  logic [WIDTH*HEIGHT-1:0] alive,
    input  logic                    frame_en,
    input  logic                    ovr_clr,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [ROW_W-1:0]        out_row,
    output logic                    out_last,
    output logic [15:0]             out_gen,
    output logic [15:0]             gen_count,
    output logic                    overrun
);

    import life_pkg::cap_fsm_t;
    import life_pkg::IDLE;
    import life_pkg::SEND;

    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(HEIGHT - 1);

    cap_fsm_t                     state_q, state_d;
    logic [HEIGHT-1:0][WIDTH-1:0] snap_q, snap_d;
    logic [ROW_W-1:0]             row_q, row_d;
    logic [15:0]                  out_gen_q, out_gen_d;
    logic [15:0]                  gen_count_q, gen_count_d;
    logic                         overrun_q, overrun_d;

    logic cap_stb;
    logic capture_req;
    logic xfer;
    logic last_xfer;
    logic load_frame;
    logic drop_frame;

    life_phase_tracker #(
        .GEN_PERIOD (GEN_PERIOD)
    ) u_phase (
        .clk       (clk),
        .nrst      (nrst),
        .cap_stb_o (cap_stb)
    );

    // A beat is only on offer in SEND, so the handshake is derived from state directly.
    assign capture_req = cap_stb & frame_en;
    assign xfer        = (state_q == SEND) & out_ready;
    assign last_xfer   = xfer & (row_q == LAST_ROW);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: a capture coinciding with the last beat keeps us in SEND.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (capture_req) state_d = SEND;
            SEND:    if (last_xfer && !capture_req) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: beat valid, accept a new frame, or drop a capture as an overrun.
    always_comb begin
        out_valid  = 1'b0;
        load_frame = 1'b0;
        drop_frame = 1'b0;
        case (state_q)
            IDLE: begin
                load_frame = capture_req;
            end
            SEND: begin
                out_valid  = 1'b1;
                load_frame = capture_req & last_xfer;
                drop_frame = capture_req & ~last_xfer;
            end
            default: begin
                out_valid = 1'b0;
            end
        endcase
    end

    // Datapath next state: snapshot, row pointer, frame tag, generation and overrun.
    always_comb begin
        snap_d      = snap_q;
        row_d       = row_q;
        out_gen_d   = out_gen_q;
        gen_count_d = cap_stb ? (gen_count_q + 16'd1) : gen_count_q;
        overrun_d   = overrun_q;

        if (load_frame) begin
            snap_d    = alive;
            row_d     = '0;
            out_gen_d = gen_count_q;
        end else if (last_xfer) begin
            row_d = '0;
        end else if (xfer) begin
            row_d = row_q + ROW_W'(1);
        end

        // A dropped capture outranks a clear arriving on the same edge.
        if (drop_frame) begin
            overrun_d = 1'b1;
        end else if (ovr_clr) begin
            overrun_d = 1'b0;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            snap_q      <= '0;
            row_q       <= '0;
            out_gen_q   <= '0;
            gen_count_q <= '0;
            overrun_q   <= 1'b0;
        end else begin
            snap_q      <= snap_d;
            row_q       <= row_d;
            out_gen_q   <= out_gen_d;
            gen_count_q <= gen_count_d;
            overrun_q   <= overrun_d;
        end
    end

    // Rows always come from the captured snapshot so live array updates never leak in.
    assign out_data  = snap_q[row_q];
    assign out_row   = row_q;
    assign out_last  = (state_q == SEND) & (row_q == LAST_ROW);
    assign out_gen   = out_gen_q;
    assign gen_count = gen_count_q;
    assign overrun   = overrun_q;

endmodule
